// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receiver state encoding and oversampling constants
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_rx_state_t;
  localparam int UART_OVERSAMPLE      = 16;
  localparam int UART_MID_START       = 7;
  localparam int UART_DBITS_DEFAULT   = 8;
  localparam int UART_SB_TICK_DEFAULT = 16;
endpackage

// File: rtl/sync_bit.sv
// sync_bit: N-flop synchronizer (clk, async rst, d_i in, q_o synchronized out, flops reset to RST_VAL)
module sync_bit #(
  parameter int   N       = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);
  logic [N-1:0] sync_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) sync_q <= {N{RST_VAL}};
    else     sync_q <= {sync_q[N-2:0], d_i};
  assign q_o = sync_q[N-1];
endmodule

// File: rtl/uart_rx_ack.sv
// uart_rx_ack: 16x oversampling UART RX (rx/sample_tick in; data_out/data_ready out with data_ack; sticky framing_error/overrun)
module uart_rx_ack
  import uart_pkg::*;
#(
  parameter int DBITS       = UART_DBITS_DEFAULT,
  parameter int SB_TICK     = UART_SB_TICK_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_100MHz,
  input  logic             reset,
  input  logic             rx,
  input  logic             sample_tick,
  input  logic             data_ack,
  output logic [DBITS-1:0] data_out,
  output logic             data_ready,
  output logic             framing_error,
  output logic             overrun
);
  localparam int BW = DBITS > 1 ? $clog2(DBITS) : 1;
  uart_rx_state_t   state_q, state_d;
  logic [4:0]       tick_q, tick_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [DBITS-1:0] shreg_q, shreg_d, sh_next, data_q, data_d;
  logic             rdy_q, rdy_d, fe_q, fe_d, ov_q, ov_d;
  logic             rx_s, done, ferr;
  sync_bit #(.N(SYNC_STAGES), .RST_VAL(1'b1)) u_sync (
    .clk(clk_100MHz), .rst(reset), .d_i(rx), .q_o(rx_s)
  );
  if (DBITS > 1) begin : g_sh
    assign sh_next = {rx_s, shreg_q[DBITS-1:1]};
  end else begin : g_sh1
    assign sh_next = rx_s;
  end
  always_ff @(posedge clk_100MHz or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      rdy_q   <= 1'b0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      rdy_q   <= rdy_d;
      fe_q    <= fe_d;
      ov_q    <= ov_d;
    end
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    done    = 1'b0;
    ferr    = 1'b0;
    case (state_q)
      IDLE: if (!rx_s) begin
        state_d = START;
        tick_d  = '0;
      end
      START: if (sample_tick) begin
        if (tick_q == 5'(UART_MID_START)) begin
          state_d = rx_s ? IDLE : DATA;
          tick_d  = '0;
          bit_d   = '0;
        end else tick_d = tick_q + 5'd1;
      end
      DATA: if (sample_tick) begin
        if (tick_q == 5'(UART_OVERSAMPLE - 1)) begin
          shreg_d = sh_next;
          tick_d  = '0;
          state_d = (bit_q == BW'(DBITS - 1)) ? STOP : DATA;
          bit_d   = bit_q + BW'(1);
        end else tick_d = tick_q + 5'd1;
      end
      STOP: if (sample_tick) begin
        if (tick_q == 5'(SB_TICK - 1)) begin
          state_d = IDLE;
          done    = rx_s;
          ferr    = !rx_s;
        end else tick_d = tick_q + 5'd1;
      end
      default: state_d = IDLE;
    endcase
    // a completion in the same cycle as data_ack wins: the new byte stays pending, no overrun
    data_d = done ? shreg_q : data_q;
    rdy_d  = done | (rdy_q & ~data_ack);
    ov_d   = ~data_ack & (ov_q | (done & rdy_q));
    fe_d   = ferr | (fe_q & ~data_ack);
  end
  assign data_out      = data_q;
  assign data_ready    = rdy_q;
  assign framing_error = fe_q;
  assign overrun       = ov_q;
endmodule

// File: tb/tb_uart_rx_ack.sv
// tb_uart_rx_ack: directed scoreboard bench for uart_rx_ack
module tb_uart_rx_ack;
  logic       clk_100MHz = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       sample_tick = 1'b0;
  logic       data_ack = 1'b0;
  logic [7:0] data_out;
  logic       data_ready, framing_error, overrun;
  int         n_cmp = 0;
  int         n_err = 0;
  int         div = 33;
  int         cnt = 0;
  logic [7:0] exp_q[$];

  uart_rx_ack dut (
    .clk_100MHz(clk_100MHz), .reset(reset), .rx(rx), .sample_tick(sample_tick),
    .data_ack(data_ack), .data_out(data_out), .data_ready(data_ready),
    .framing_error(framing_error), .overrun(overrun)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  initial forever begin
    @(negedge clk_100MHz);
    sample_tick = (cnt == div - 1);
    cnt = (cnt >= div - 1) ? 0 : cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      @(posedge clk_100MHz);
      while (!sample_tick) @(posedge clk_100MHz);
    end
    @(negedge clk_100MHz);
  endtask

  task automatic check_byte(input string tag);
    logic [7:0] e;
    e = exp_q[$];
    exp_q = {};
    chk(tag, data_out, e);
  endtask

  task automatic pulse_ack();
    data_ack = 1'b1;
    @(negedge clk_100MHz);
    data_ack = 1'b0;
    #1;
  endtask

  task automatic wait_rise();
    bit prev = 1'b0;
    bit got = 1'b0;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clk_100MHz);
      #1;
      if (data_ready) begin
        got = 1'b1;
        chk("rise_after_tick", prev, 1);
      end
      prev = sample_tick;
    end
    if (!got) chk("ready_rise_timeout", data_ready, 1);
  endtask

  task automatic send_bits(input logic [7:0] b);
    ticks(1);
    rx = 1'b0;
    ticks(16);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      ticks(16);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic stop, input bit watch);
    send_bits(b);
    rx = stop;
    if (stop) exp_q.push_back(b);
    if (watch) wait_rise();
    else ticks(10);
    rx = 1'b1;
    ticks(6);
  endtask

  initial begin
    #1;
    chk("rst_data", data_out, 0);
    chk("rst_ready", data_ready, 0);
    chk("rst_fe", framing_error, 0);
    chk("rst_ov", overrun, 0);
    repeat (3) @(negedge clk_100MHz);
    reset = 1'b0;
    repeat (2000) @(negedge clk_100MHz);
    #1;
    chk("idle_data", data_out, 0);
    chk("idle_ready", data_ready, 0);
    chk("idle_fe", framing_error, 0);
    chk("idle_ov", overrun, 0);
    div = 4;
    send(8'h55, 1'b1, 1'b1);
    check_byte("rx_55");
    chk("rx_55_fe", framing_error, 0);
    chk("rx_55_ov", overrun, 0);
    pulse_ack();
    chk("ack_55_ready", data_ready, 0);
    send(8'hA5, 1'b1, 1'b0);
    send(8'h3C, 1'b1, 1'b0);
    check_byte("ovr_data");
    chk("ovr_ready", data_ready, 1);
    chk("ovr_flag", overrun, 1);
    chk("ovr_fe", framing_error, 0);
    pulse_ack();
    chk("ovr_ack_ready", data_ready, 0);
    chk("ovr_ack_flag", overrun, 0);
    send(8'h81, 1'b0, 1'b0);
    chk("fe_flag", framing_error, 1);
    chk("fe_data_hold", data_out, 8'h3C);
    chk("fe_ready", data_ready, 0);
    pulse_ack();
    chk("fe_ack", framing_error, 0);
    ticks(1);
    rx = 1'b0;
    ticks(4);
    rx = 1'b1;
    ticks(20);
    chk("glitch_ready", data_ready, 0);
    chk("glitch_fe", framing_error, 0);
    chk("glitch_data", data_out, 8'h3C);
    send(8'h0F, 1'b1, 1'b1);
    check_byte("rx_0f");
    chk("rx_0f_fe", framing_error, 0);
    ticks(1);
    rx = 1'b0;
    ticks(16);
    rx = 1'b1;
    ticks(40);
    reset = 1'b1;
    #1;
    chk("midrst_data", data_out, 0);
    chk("midrst_ready", data_ready, 0);
    chk("midrst_fe", framing_error, 0);
    chk("midrst_ov", overrun, 0);
    repeat (3) @(negedge clk_100MHz);
    reset = 1'b0;
    send(8'h34, 1'b1, 1'b1);
    check_byte("rx_34");
    send_bits(8'h12);
    rx = 1'b1;
    exp_q.push_back(8'h12);
    ticks(7);
    for (int c = 0; c < 10; c++) begin
      #1;
      if (sample_tick) break;
      @(negedge clk_100MHz);
    end
    data_ack = 1'b1;
    @(negedge clk_100MHz);
    data_ack = 1'b0;
    #1;
    check_byte("ackcoin_data");
    chk("ackcoin_ready", data_ready, 1);
    chk("ackcoin_ov", overrun, 0);
    ticks(8);
    pulse_ack();
    chk("final_ready", data_ready, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
